// File: rtl/shift_add_mult_seq.sv
// Sequential shift-and-add multiplier: one multiplier bit retired per clock,
// start/done handshake, optional two's-complement operands via magnitude + sign fix.
module shift_add_mult_seq #(
  parameter int M = 8,
  parameter int N = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_signed_mode,
  input  logic [M-1:0]   i_d,
  input  logic [N-1:0]   i_q,
  output logic           o_busy,
  output logic           o_done,
  output logic [M+N-1:0] o_product
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t          r_state;
  logic [M:0]      r_a;
  logic [N-1:0]    r_q;
  logic [M-1:0]    r_mag_d;
  logic            r_neg;
  logic [CW-1:0]   r_cnt;

  logic [M-1:0]    w_mag_d;
  logic [N-1:0]    w_mag_q;
  logic [M:0]      w_sum;
  logic [M+N-1:0]  w_full;

  // Negating the most-negative value wraps back to itself, which read as
  // unsigned is exactly its magnitude.
  assign w_mag_d = (i_signed_mode && i_d[M-1]) ? -i_d : i_d;
  assign w_mag_q = (i_signed_mode && i_q[N-1]) ? -i_q : i_q;
  assign w_sum   = r_q[0] ? (r_a + {1'b0, r_mag_d}) : r_a;
  assign w_full  = {r_a[M-1:0], r_q};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_q       <= '0;
      r_mag_d   <= '0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_mag_d <= w_mag_d;
            r_q     <= w_mag_q;
            r_neg   <= i_signed_mode & (i_d[M-1] ^ i_q[N-1]);
            r_a     <= '0;
            r_cnt   <= '0;
            o_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          // add and shift in one step: carry lands in the accumulator MSB
          r_a   <= {1'b0, w_sum[M:1]};
          r_q   <= {w_sum[0], r_q[N-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(N-1)) r_state <= S_FIX;
        end
        S_FIX: begin
          o_product <= r_neg ? -w_full : w_full;
          o_done    <= 1'b1;
          o_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Bench for shift_add_mult_seq: 8x8 vector table, handshake and reset sequences,
// and a 12x5 random sweep, all checked through per-instance scoreboards.
module tb_shift_add_mult_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s8 = 0, sm8 = 0, b8, dn8;
  logic [7:0]  d8 = 0, q8 = 0;
  logic [15:0] p8;
  logic        s12 = 0, sm12 = 0, b12, dn12;
  logic [11:0] d12 = 0;
  logic [4:0]  q12 = 0;
  logic [16:0] p12;

  shift_add_mult_seq #(.M(8), .N(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(s8), .i_signed_mode(sm8), .i_d(d8), .i_q(q8),
    .o_busy(b8), .o_done(dn8), .o_product(p8));
  shift_add_mult_seq #(.M(12), .N(5)) u_dut12 (
    .i_clk(clk), .i_rst(rst), .i_start(s12), .i_signed_mode(sm12), .i_d(d12), .i_q(q12),
    .o_busy(b12), .o_done(dn12), .o_product(p12));

  int n_cmp = 0, n_bad = 0;
  logic [15:0] sb8[$];
  logic [16:0] sb12[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [16:0] ref12(input logic [11:0] d, input logic [4:0] q, input logic sm);
    logic [16:0] a, b;
    a = sm ? {{5{d[11]}}, d} : {5'b0, d};
    b = sm ? {{12{q[4]}}, q} : {12'b0, q};
    return a * b;
  endfunction

  // scoreboard checkers: every done pops one expected product
  logic pd8 = 0, pd12 = 0;
  always @(negedge clk) begin
    if (dn8) begin
      chk("done8_busy_low", {31'b0, b8}, 0);
      chk("done8_single", {31'b0, pd8}, 0);
      if (sb8.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL done8_unexpected: got done, want none");
      end else chk("prod8", {16'b0, p8}, {16'b0, sb8.pop_front()});
    end
    pd8 = dn8;
  end
  always @(negedge clk) begin
    if (dn12) begin
      chk("done12_busy_low", {31'b0, b12}, 0);
      chk("done12_single", {31'b0, pd12}, 0);
      if (sb12.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL done12_unexpected: got done, want none");
      end else chk("prod12", {15'b0, p12}, {15'b0, sb12.pop_front()});
    end
    pd12 = dn12;
  end

  task automatic op8(input logic [7:0] d, input logic [7:0] q, input logic sm,
                     input logic [15:0] exp, input string nm);
    int n, nb;
    @(posedge clk); #1;
    d8 = d; q8 = q; sm8 = sm; s8 = 1; sb8.push_back(exp);
    @(posedge clk); #1;
    s8 = 0; d8 = ~d; q8 = ~q; sm8 = ~sm;
    n = 0; nb = 0;
    @(negedge clk);
    while (!dn8 && n < 40) begin
      if (b8) nb++;
      @(negedge clk); n++;
    end
    chk({nm, "_lat"}, n, 9);
    chk({nm, "_busy"}, nb, 9);
  endtask

  task automatic op12(input logic [11:0] d, input logic [4:0] q, input logic sm, input string nm);
    int n, nb;
    @(posedge clk); #1;
    d12 = d; q12 = q; sm12 = sm; s12 = 1; sb12.push_back(ref12(d, q, sm));
    @(posedge clk); #1;
    s12 = 0; d12 = ~d; q12 = ~q;
    n = 0; nb = 0;
    @(negedge clk);
    while (!dn12 && n < 40) begin
      if (b12) nb++;
      @(negedge clk); n++;
    end
    chk({nm, "_lat"}, n, 6);
    chk({nm, "_busy"}, nb, 6);
  endtask

  typedef struct {
    logic [7:0]  d;
    logic [7:0]  q;
    logic        sm;
    logic [15:0] exp;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    int n;
    tbl[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[2] = '{8'h80, 8'h01, 1'b1, 16'hFF80};
    tbl[3] = '{8'h05, 8'hFD, 1'b1, 16'hFFF1};
    tbl[4] = '{8'h00, 8'hA5, 1'b0, 16'h0000};
    tbl[5] = '{8'h1F, 8'h1F, 1'b0, 16'h03C1};
    tbl[6] = '{8'h01, 8'h01, 1'b0, 16'h0001};
    tbl[7] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    tbl[8] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};

    #12;
    chk("rst_busy8", {31'b0, b8}, 0);
    chk("rst_done8", {31'b0, dn8}, 0);
    chk("rst_prod8", {16'b0, p8}, 0);
    chk("rst_busy12", {31'b0, b12}, 0);
    chk("rst_done12", {31'b0, dn12}, 0);
    chk("rst_prod12", {15'b0, p12}, 0);
    @(posedge clk); #1 rst = 0;

    for (int i = 0; i < 9; i++) op8(tbl[i].d, tbl[i].q, tbl[i].sm, tbl[i].exp, $sformatf("vec%0d", i));

    // start held high; D change after accept must be ignored, and the
    // second operation is taken in the done cycle with the new D
    @(posedge clk); #1;
    d8 = 8'd3; q8 = 8'd7; sm8 = 0; s8 = 1;
    sb8.push_back(16'h0015); sb8.push_back(16'h003F);
    @(posedge clk); #1 d8 = 8'd9;
    n = 0;
    @(negedge clk);
    while (!dn8 && n < 40) begin @(negedge clk); n++; end
    chk("hs_lat1", n, 9);
    @(posedge clk); #1;
    chk("hs_reaccept_busy", {31'b0, b8}, 1);
    chk("hs_done_dropped", {31'b0, dn8}, 0);
    s8 = 0;
    n = 0;
    @(negedge clk);
    while (!dn8 && n < 40) begin
      if (n == 4) chk("hs_prod_held", {16'b0, p8}, 32'h15);
      @(negedge clk); n++;
    end
    chk("hs_lat2", n, 9);

    // asynchronous reset mid-CALC aborts with no done
    @(posedge clk); #1;
    d8 = 8'h55; q8 = 8'h33; sm8 = 0; s8 = 1;
    @(posedge clk); #1 s8 = 0;
    repeat (4) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("arst_busy", {31'b0, b8}, 0);
    chk("arst_done", {31'b0, dn8}, 0);
    chk("arst_prod", {16'b0, p8}, 0);
    @(negedge clk); @(posedge clk); #1 rst = 0;
    repeat (12) @(posedge clk);
    op8(8'h55, 8'h33, 1'b0, 16'h10EF, "post_rst");

    op12(12'h800, 5'h10, 1'b1, "w12_minmin");
    op12(12'h800, 5'h0F, 1'b1, "w12_minpos");
    op12(12'hFFF, 5'h1F, 1'b0, "w12_maxu");
    op12(12'h7FF, 5'h10, 1'b1, "w12_posmin");
    for (int i = 0; i < 12; i++)
      op12(12'($urandom), 5'($urandom), 1'($urandom_range(0, 1)), $sformatf("w12_rnd%0d", i));

    repeat (3) @(posedge clk);
    chk("sb8_drained", sb8.size(), 0);
    chk("sb12_drained", sb12.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
